mc_ctrl_fsm: RTL and testbench

Main control state machine for the multicycle MIPS datapath. It decodes the latched instruction opcode and sequences the shared ALU, memory port, IR, PC and register file over 3-5 cycles per instruction. It drives a 2-bit alu_op to the ALU control decoder and stalls on a single-port memory ready handshake. Supported instructions are R-type, lw, sw, beq, j and addi; any other opcode raises a one-cycle illegal_op pulse.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mc_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux selects and FSM states.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB, S_ILLEGAL
   } state_t;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM; 3-5 cycles per instruction when memory is ready.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; outputs are a Moore decode except the mem_ready strobes.
module mc_ctrl_fsm
   import mips_pkg::*;
#(
   parameter int unsigned RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [5:0]              opcode,
   input  logic                    mem_ready,
   input  logic                    zero,
   output logic                    pc_write,
   output logic                    pc_write_cond,
   output logic                    i_or_d,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    ir_write,
   output logic                    mem_to_reg,
   output logic                    reg_dst,
   output logic                    reg_write,
   output logic                    alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [1:0]              alu_op,
   output logic [1:0]              pc_src,
   output logic                    illegal_op,
   output logic                    retire,
   output logic [RETIRE_CNT_W-1:0] retire_cnt
);

   state_t state, state_nxt;

   // The branch qualify happens in the datapath; zero is only passed alongside.
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_RST;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RST:    state_nxt = S_FETCH;
         S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_nxt = S_EXEC;
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
               OP_ADDI:      state_nxt = S_ADDIEX;
               default:      state_nxt = S_ILLEGAL;
            endcase
         end
         S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
         S_MEMWB:  state_nxt = S_FETCH;
         S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
         S_EXEC:   state_nxt = S_ALUWB;
         S_ALUWB:  state_nxt = S_FETCH;
         S_BRANCH: state_nxt = S_FETCH;
         S_JUMP:   state_nxt = S_FETCH;
         S_ADDIEX: state_nxt = S_ADDIWB;
         S_ADDIWB: state_nxt = S_FETCH;
         S_ILLEGAL: state_nxt = S_FETCH;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALUOP_ADD;
      pc_src        = PCSRC_ALU;
      illegal_op    = 1'b0;
      retire        = 1'b0;
      case (state)
         S_FETCH: begin
            // IR and PC load only on the completing beat so a stalled fetch updates them once.
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMM_SH;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            retire    = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PCSRC_ALUOUT;
            retire        = 1'b1;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_JUMP;
            retire   = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         S_ILLEGAL: illegal_op = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      retire_cnt <= '0;
      else if (retire) retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed plus randomized instruction stream against a per-instruction phase model of the control path.
module tb_mc_ctrl_fsm;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    opcode = '0;
   logic          mem_ready = 1'b0;
   logic          zero = 1'b0;
   logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]    alu_src_b, alu_op, pc_src;
   logic          illegal_op, retire;
   logic [CW-1:0] retire_cnt;

   mc_ctrl_fsm #(.RETIRE_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .illegal_op(illegal_op), .retire(retire), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
      logic       retire;
   } outs_t;

   outs_t act;
   always_comb act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_src, illegal_op, retire};

   int n_cmp = 0;
   int n_fail = 0;
   int model_cnt = 0;
   int ir_pulses = 0;
   int ill_pulses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected output word for each phase of an instruction, straight from the control table.
   function automatic outs_t ph_fetch(input logic mr);
      outs_t e = '0;
      e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr;
      return e;
   endfunction
   function automatic outs_t ph_decode();
      outs_t e = '0; e.alu_src_b = 2'b11; return e;
   endfunction
   function automatic outs_t ph_addr();
      outs_t e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; return e;
   endfunction
   function automatic outs_t ph_memrd();
      outs_t e = '0; e.mem_read = 1; e.i_or_d = 1; return e;
   endfunction
   function automatic outs_t ph_memwb();
      outs_t e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; return e;
   endfunction
   function automatic outs_t ph_memwr(input logic mr);
      outs_t e = '0; e.mem_write = 1; e.i_or_d = 1; e.retire = mr; return e;
   endfunction
   function automatic outs_t ph_exec();
      outs_t e = '0; e.alu_src_a = 1; e.alu_op = 2'b10; return e;
   endfunction
   function automatic outs_t ph_aluwb();
      outs_t e = '0; e.reg_write = 1; e.reg_dst = 1; e.retire = 1; return e;
   endfunction
   function automatic outs_t ph_branch();
      outs_t e = '0;
      e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_src = 2'b01; e.retire = 1;
      return e;
   endfunction
   function automatic outs_t ph_jump();
      outs_t e = '0; e.pc_write = 1; e.pc_src = 2'b10; e.retire = 1; return e;
   endfunction
   function automatic outs_t ph_addiwb();
      outs_t e = '0; e.reg_write = 1; e.retire = 1; return e;
   endfunction
   function automatic outs_t ph_illegal();
      outs_t e = '0; e.illegal_op = 1; return e;
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};
   endfunction

   task automatic step(input outs_t e, input logic mr, input logic [5:0] op, input string tag);
      @(negedge clk);
      mem_ready = mr;
      opcode    = op;
      zero      = 1'($urandom);
      #1;
      check({tag, " outs"}, 32'(act), 32'(e));
      check({tag, " cnt"}, 32'(retire_cnt), 32'(model_cnt));
      check({tag, " excl"}, 32'((mem_read & mem_write) | (reg_write & mem_write)), 32'd0);
      if (act.ir_write === 1'b1) ir_pulses++;
      if (act.illegal_op === 1'b1) ill_pulses++;
      if (e.retire) model_cnt = (model_cnt + 1) % (1 << CW);
   endtask

   task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
      ir_pulses  = 0;
      ill_pulses = 0;
      for (int i = 0; i < fs; i++) step(ph_fetch(1'b0), 1'b0, 6'($urandom), "fetch_stall");
      step(ph_fetch(1'b1), 1'b1, 6'($urandom), "fetch");
      step(ph_decode(), 1'($urandom), op, "decode");
      case (op)
         6'd0: begin
            step(ph_exec(), 1'($urandom), op, "exec");
            step(ph_aluwb(), 1'($urandom), op, "aluwb");
         end
         6'd35: begin
            step(ph_addr(), 1'($urandom), op, "memadr_lw");
            for (int i = 0; i < ms; i++) step(ph_memrd(), 1'b0, op, "memrd_stall");
            step(ph_memrd(), 1'b1, op, "memrd");
            step(ph_memwb(), 1'($urandom), op, "memwb");
         end
         6'd43: begin
            step(ph_addr(), 1'($urandom), op, "memadr_sw");
            for (int i = 0; i < ms; i++) step(ph_memwr(1'b0), 1'b0, op, "memwr_stall");
            step(ph_memwr(1'b1), 1'b1, op, "memwr");
         end
         6'd4:  step(ph_branch(), 1'($urandom), op, "branch");
         6'd2:  step(ph_jump(), 1'($urandom), op, "jump");
         6'd8: begin
            step(ph_addr(), 1'($urandom), op, "addiex");
            step(ph_addiwb(), 1'($urandom), op, "addiwb");
         end
         default: step(ph_illegal(), 1'($urandom), op, "illegal");
      endcase
      check("ir_once", 32'(ir_pulses), 32'd1);
      check("ill_pulse", 32'(ill_pulses), is_legal(op) ? 32'd0 : 32'd1);
   endtask

   logic [5:0] legal_ops [6] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};

   initial begin
      logic [5:0] op;

      mem_ready = 1'b1;
      #3;
      check("reset_outs", 32'(act), 32'd0);
      check("reset_cnt", 32'(retire_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_state_outs", 32'(act), 32'd0);

      // Back-to-back R-type: retire every 4th cycle, count of 3 after 12 cycles.
      for (int i = 0; i < 3; i++) run_instr(6'd0, 0, 0);
      @(posedge clk); #1;
      check("rtype_cnt3", 32'(retire_cnt), 32'd3);

      run_instr(6'd35, 2, 2);
      run_instr(6'd43, 1, 2);
      run_instr(6'd4, 0, 0);
      run_instr(6'd2, 0, 0);
      run_instr(6'd63, 0, 0);
      run_instr(6'd8, 0, 0);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 6) == 6) begin
            op = 6'($urandom);
            while (is_legal(op)) op = 6'($urandom);
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Abort a load in MEMRD with an asynchronous reset between clock edges.
      step(ph_fetch(1'b1), 1'b1, 6'd0, "abort_fetch");
      step(ph_decode(), 1'b1, 6'd35, "abort_decode");
      step(ph_addr(), 1'b1, 6'd35, "abort_memadr");
      step(ph_memrd(), 1'b0, 6'd35, "abort_memrd");
      @(negedge clk);
      mem_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_outs", 32'(act), 32'd0);
      check("async_rst_cnt", 32'(retire_cnt), 32'd0);
      model_cnt = 0;
      @(negedge clk);
      #1;
      check("held_rst_outs", 32'(act), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rerst_state_outs", 32'(act), 32'd0);
      run_instr(6'd0, 0, 0);
      run_instr(6'd35, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
